// File: rtl/pokey_pkg.sv
// Shared POKEY package.
//   Reset values for the cell's write latch (DL) and counter bit (Q), the
//   width of the down-counter chains built from pokey_cell20, and a helper
//   that forms the borrow-out of one cell.
package pokey_pkg;

   localparam logic        DL_RST  = 1'b0;
   localparam logic        Q_RST   = 1'b0;
   localparam int unsigned CHAIN_W = 8;

   // A borrow leaves the cell only for a legal borrow-in (cr=1, ncr=0)
   // while the bit sits at 0, i.e. when it is about to wrap 0 -> 1.
   function automatic logic borrow_out(input logic cr, input logic ncr, input logic q);
      return cr & ~ncr & ~q;
   endfunction

endpackage

// File: rtl/pokey_cell20_if.sv
// Bus bundle for one pokey_cell20 bit-slice.
//   enn      : one-clk enable pulse (1.79 MHz falling edge)
//   d        : CPU data bit
//   wr       : write strobe (d -> write latch)
//   ld       : load strobe (write latch -> counter bit)
//   cr / ncr : borrow-in, true / complement
//   bor/nbor : borrow-out, true / complement
// master drives the strobes and reads the borrow-out; slave is the cell.
interface pokey_cell20_if;

   logic enn;
   logic d;
   logic wr;
   logic ld;
   logic cr;
   logic ncr;
   logic bor;
   logic nbor;

   modport master (
      output enn, d, wr, ld, cr, ncr,
      input  bor, nbor
   );

   modport slave (
      input  enn, d, wr, ld, cr, ncr,
      output bor, nbor
   );

endinterface

// File: rtl/pokey_en_dff.sv
// Enabled D flip-flop with asynchronous active-high reset.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; forces q to RST_VAL
//   en    : capture enable
//   d     : next value
//   q     : registered value
module pokey_en_dff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic d,
   output logic q
);

   // State register: capture d only on enabled edges.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= RST_VAL;
      end else if (en) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/pokey_cell20.sv
// One bit-slice of the POKEY down-counter chain.
//   clk   : system clock, all state changes on its rising edge
//   reset : asynchronous, active-high; clears write latch and counter bit
//   bus   : pokey_cell20_if.slave (enn, d, wr, ld, cr, ncr in; bor, nbor out)
// The write latch captures d on wr; the counter bit loads the latch on ld or
// toggles on a legal borrow-in. Every change is qualified by enn.
// Borrow-out is combinational from cr/ncr and the counter bit.
// Optional build macro: CELL20_WR_BYPASS_EN -- when wr and ld coincide, the
// counter bit loads the incoming d directly instead of the old latch value.
module pokey_cell20
   import pokey_pkg::*;
(
   input logic            clk,
   input logic            reset,
   pokey_cell20_if.slave  bus
);

   logic dl_r;
   logic q_r;
   logic dl_next_s;
   logic q_next_s;
   logic bor_s;

   // Next-state selection for the write latch and the counter bit.
   always_comb begin
      dl_next_s = dl_r;
      q_next_s  = q_r;
      if (bus.wr) begin
         dl_next_s = bus.d;
      end else begin
         dl_next_s = dl_r;
      end
      if (bus.ld) begin
`ifdef CELL20_WR_BYPASS_EN
         // Write-through: a same-enable write reaches the counter at once.
         if (bus.wr) begin
            q_next_s = bus.d;
         end else begin
            q_next_s = dl_r;
         end
`else
         // Load uses the latch value from before this edge.
         q_next_s = dl_r;
`endif
      end else if (bus.cr && !bus.ncr) begin
         q_next_s = ~q_r;
      end else begin
         // No borrow, or the illegal cr==ncr combination.
         q_next_s = q_r;
      end
   end

   pokey_en_dff #(.RST_VAL(DL_RST)) u_dl (
      .clk   (clk),
      .reset (reset),
      .en    (bus.enn),
      .d     (dl_next_s),
      .q     (dl_r)
   );

   pokey_en_dff #(.RST_VAL(Q_RST)) u_q (
      .clk   (clk),
      .reset (reset),
      .en    (bus.enn),
      .d     (q_next_s),
      .q     (q_r)
   );

   assign bor_s    = borrow_out(bus.cr, bus.ncr, q_r);
   assign bus.bor  = bor_s;
   assign bus.nbor = ~bor_s;

endmodule

// File: tb/tb_pokey_cell20.sv
// Self-checking bench for pokey_cell20: directed scenarios plus randomized
// strobes compared against a bit-level reference model of the cell's rules.
module tb_pokey_cell20;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   // reference model state
   logic m_dl;
   logic m_q;

`ifdef CELL20_WR_BYPASS_EN
   localparam logic BYPASS = 1'b1;
`else
   localparam logic BYPASS = 1'b0;
`endif

   pokey_cell20_if bus ();

   pokey_cell20 dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic idle();
      bus.enn = 1'b0; bus.d = 1'b0; bus.wr = 1'b0;
      bus.ld  = 1'b0; bus.cr = 1'b0; bus.ncr = 1'b1;
   endtask

   // Wait for a rising edge, advance the model with the inputs held there.
   task automatic tick();
      logic old_dl;
      @(posedge clk);
      if (!reset && bus.enn) begin
         old_dl = m_dl;
         if (bus.wr) m_dl = bus.d;
         if (bus.ld) m_q = (BYPASS && bus.wr) ? bus.d : old_dl;
         else if (bus.cr && !bus.ncr) m_q = ~m_q;
      end
      #1;
   endtask

   // Read the counter bit through the borrow path without any clock edge.
   task automatic probe_q(output logic qv);
      logic sv_cr, sv_ncr, sv_enn;
      sv_cr = bus.cr; sv_ncr = bus.ncr; sv_enn = bus.enn;
      bus.enn = 1'b0; bus.cr = 1'b1; bus.ncr = 1'b0;
      #1;
      qv = ~bus.bor;
      bus.cr = sv_cr; bus.ncr = sv_ncr; bus.enn = sv_enn;
      #1;
   endtask

   // Put value v into both DL and Q using one write and one load enable.
   task automatic preset(input logic v);
      idle(); bus.enn = 1'b1; bus.d = v; bus.wr = 1'b1; tick();
      idle(); bus.enn = 1'b1; bus.ld = 1'b1; tick();
      idle();
   endtask

   task automatic test_reset();
      logic qv;
      reset = 1'b1; m_dl = 1'b0; m_q = 1'b0;
      idle(); bus.cr = 1'b1; bus.ncr = 1'b0;
      #1;
      checks++;
      if (bus.bor !== 1'b1 || bus.nbor !== 1'b0) begin
         errors++; $display("FAIL reset_initial bor=%b nbor=%b required bor=1 nbor=0", bus.bor, bus.nbor);
      end
      @(negedge clk); reset = 1'b0; idle();
      preset(1'b1);
      probe_q(qv);
      checks++;
      if (qv !== 1'b1) begin
         errors++; $display("FAIL reset_preload q=%b required 1", qv);
      end
      // assert reset mid-cycle, away from any edge
      @(negedge clk);
      bus.cr = 1'b1; bus.ncr = 1'b0;
      reset = 1'b1; m_dl = 1'b0; m_q = 1'b0;
      #1;
      checks++;
      if (bus.bor !== 1'b1 || bus.nbor !== 1'b0) begin
         errors++; $display("FAIL reset_async bor=%b nbor=%b required bor=1 nbor=0", bus.bor, bus.nbor);
      end
      @(negedge clk); reset = 1'b0; idle();
      // DL must have been cleared: loading it gives Q=0
      bus.enn = 1'b1; bus.ld = 1'b1; tick(); idle();
      probe_q(qv);
      checks++;
      if (qv !== 1'b0 || qv !== m_q) begin
         errors++; $display("FAIL reset_dl_cleared q=%b required 0", qv);
      end
   endtask

   task automatic test_write_load();
      logic qv;
      preset(1'b0);
      bus.enn = 1'b1; bus.d = 1'b1; bus.wr = 1'b1; tick(); idle();
      probe_q(qv);
      checks++;
      if (qv !== 1'b0) begin
         errors++; $display("FAIL write_before_load q=%b required 0", qv);
      end
      bus.enn = 1'b1; bus.ld = 1'b1; tick(); idle();
      bus.cr = 1'b1; bus.ncr = 1'b0; #1;
      checks++;
      if (bus.bor !== 1'b0 || bus.nbor !== 1'b1 || m_q !== 1'b1) begin
         errors++; $display("FAIL write_load bor=%b nbor=%b required bor=0 nbor=1", bus.bor, bus.nbor);
      end
      idle();
   endtask

   task automatic test_toggle();
      logic [2:0] seq;
      seq = 3'b010; // Q after pulse 1,2,3 is 0,1,0 (bit i = pulse i+1)
      preset(1'b1);
      bus.cr = 1'b1; bus.ncr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.enn = 1'b1; tick();
         bus.enn = 1'b0; tick();
         checks++;
         if (bus.bor !== ~seq[i] || bus.nbor !== seq[i]) begin
            errors++; $display("FAIL toggle_%0d bor=%b nbor=%b required bor=%b", i, bus.bor, bus.nbor, ~seq[i]);
         end
      end
      idle();
   endtask

   task automatic test_enable_gating();
      logic qv;
      preset(1'b1);
      bus.enn = 1'b0; bus.d = 1'b0; bus.wr = 1'b1; bus.ld = 1'b1;
      bus.cr = 1'b1; bus.ncr = 1'b0;
      repeat (4) tick();
      idle();
      probe_q(qv);
      checks++;
      if (qv !== 1'b1) begin
         errors++; $display("FAIL gating_q q=%b required 1", qv);
      end
      bus.enn = 1'b1; bus.ld = 1'b1; preset_skip: tick(); idle();
      probe_q(qv);
      checks++;
      if (qv !== 1'b1) begin
         errors++; $display("FAIL gating_dl loaded q=%b required 1", qv);
      end
   endtask

   task automatic test_priority();
      logic qv;
      preset(1'b0);
      bus.enn = 1'b1; bus.d = 1'b1; bus.wr = 1'b1; tick(); idle();
      bus.enn = 1'b1; bus.ld = 1'b1; bus.cr = 1'b1; bus.ncr = 1'b0; tick(); idle();
      probe_q(qv);
      checks++;
      if (qv !== 1'b1) begin
         errors++; $display("FAIL priority q=%b required 1", qv);
      end
      // illegal borrow-in (cr==ncr) must not toggle
      bus.enn = 1'b1; bus.cr = 1'b1; bus.ncr = 1'b1; tick(); bus.enn = 1'b0;
      #1;
      checks++;
      if (bus.bor !== 1'b0 || bus.nbor !== 1'b1) begin
         errors++; $display("FAIL illegal_borrow_out bor=%b required 0", bus.bor);
      end
      idle();
      probe_q(qv);
      checks++;
      if (qv !== 1'b1) begin
         errors++; $display("FAIL illegal_no_toggle q=%b required 1", qv);
      end
   endtask

   task automatic test_macro();
      logic qv;
      preset(1'b0);
      bus.enn = 1'b1; bus.d = 1'b1; bus.wr = 1'b1; bus.ld = 1'b1; tick(); idle();
      probe_q(qv);
      checks++;
      if (qv !== BYPASS) begin
         errors++; $display("FAIL macro_wr_ld q=%b required %b", qv, BYPASS);
      end
      bus.enn = 1'b1; bus.ld = 1'b1; tick(); idle();
      probe_q(qv);
      checks++;
      if (qv !== 1'b1) begin
         errors++; $display("FAIL macro_late_load q=%b required 1", qv);
      end
   endtask

   task automatic test_random();
      logic exp_bor;
      for (int n = 0; n < 400; n++) begin
         bus.enn = ($urandom_range(0, 1) == 0);
         bus.d   = $urandom_range(0, 1);
         bus.wr  = ($urandom_range(0, 2) == 0);
         bus.ld  = ($urandom_range(0, 3) == 0);
         bus.cr  = $urandom_range(0, 1);
         bus.ncr = ($urandom_range(0, 7) == 0) ? bus.cr : ~bus.cr;
         #1;
         exp_bor = bus.cr && !bus.ncr && !m_q;
         checks++;
         if (bus.bor !== exp_bor || bus.nbor !== ~exp_bor) begin
            errors++;
            $display("FAIL random_%0d bor=%b nbor=%b required bor=%b nbor=%b", n, bus.bor, bus.nbor, exp_bor, ~exp_bor);
         end
         tick();
      end
      idle();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_dl = 1'b0;
      m_q  = 1'b0;
      reset = 1'b1;
      idle();
      test_reset();
      test_write_load();
      test_toggle();
      test_enable_gating();
      test_priority();
      test_macro();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
